// File: rtl/hba_arbiter.sv
// HBA bus-grant stage: round-robin one-hot grant with a dead release cycle,
// plus a transfer watchdog that substitutes a missing slave acknowledge.
module hba_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                   hba_clk,
   input  logic                   hba_reset,
   input  logic [NUM_MASTERS-1:0] master_request,
   output logic [NUM_MASTERS-1:0] hba_mgrant,
   input  logic                   hba_select,
   input  logic                   hba_xferack,
   output logic                   timeout_xferack,
   output logic                   timeout_err,
   input  logic                   err_clear,
   output logic                   bus_busy
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_MASTERS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_HIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t                 state, state_d;
   logic [IDX_W-1:0]       last_grant, last_d;
   logic [NUM_MASTERS-1:0] grant_d;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;
   logic                   owner_req;
   logic                   release_now;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   tmo;

   // First requester searching upward from the slot after the last owner
   always_comb begin
      int j;
      j          = 0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         j = (int'(last_grant) + i) % NUM_MASTERS;
         if (!pick_valid && master_request[IDX_W'(j)]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(j);
         end
      end
   end

   assign owner_req   = master_request[last_grant];
   assign release_now = !owner_req && !hba_select;

   always_ff @(posedge hba_clk or negedge hba_reset) begin
      if (!hba_reset) begin
         state      <= IDLE;
         last_grant <= LAST_INIT;
         hba_mgrant <= '0;
      end else begin
         state      <= state_d;
         last_grant <= last_d;
         hba_mgrant <= grant_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (pick_valid) state_d = GRANT;
         GRANT:   if (release_now) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d  = hba_mgrant;
      last_d   = last_grant;
      bus_busy = (state == GRANT);
      unique case (state)
         IDLE: begin
            grant_d = '0;
            if (pick_valid) begin
               grant_d = NUM_MASTERS'(1) << pick_idx;
               last_d  = pick_idx;
            end
         end
         GRANT:   if (release_now) grant_d = '0;
         RELEASE: grant_d = '0;
         default: grant_d = '0;
      endcase
   end

   // A real acknowledge in the timeout cycle wins over the substitute
   assign tmo = hba_select && !hba_xferack && (cnt == CNT_HIT);

   always_ff @(posedge hba_clk or negedge hba_reset) begin
      if (!hba_reset) begin
         cnt             <= '0;
         timeout_xferack <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         timeout_xferack <= tmo;
         if (!hba_select || hba_xferack || tmo)
            cnt <= '0;
         else if (cnt != CNT_SAT)
            cnt <= cnt + 1'b1;
         if (tmo)
            timeout_err <= 1'b1;
         else if (err_clear)
            timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed bench for hba_arbiter: grant latency, hold, release gap,
// round-robin order, select hold, watchdog and asynchronous reset.
module tb_hba_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       sel;
   logic       ack;
   logic       txa;
   logic       err;
   logic       eclr;
   logic       busy;

   int errors;
   int checks;

   hba_arbiter #(
      .NUM_MASTERS   (4),
      .TIMEOUT_CYCLES(8),
      .CNT_WIDTH     (8)
   ) dut (
      .hba_clk        (clk),
      .hba_reset      (rst_n),
      .master_request (req),
      .hba_mgrant     (gnt),
      .hba_select     (sel),
      .hba_xferack    (ack),
      .timeout_xferack(txa),
      .timeout_err    (err),
      .err_clear      (eclr),
      .bus_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int seq [5] = '{0, 1, 2, 3, 0};

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      req    = '0;
      sel    = 1'b0;
      ack    = 1'b0;
      eclr   = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_txa", 32'(txa), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("idle_gnt", 32'(gnt), 32'h0);

      // single request, one-cycle latency
      req = 4'b0100;
      tick();
      chk("m2_gnt", 32'(gnt), 32'h4);
      chk("m2_busy", 32'(busy), 32'h1);

      // others request meanwhile; no preemption for 10 cycles
      req = 4'b1101;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("m2_hold", 32'(gnt), 32'h4);
      end
      req = 4'b1001;
      tick();
      chk("rel_gap", 32'(gnt), 32'h0);
      chk("rel_busy", 32'(busy), 32'h0);
      tick();
      chk("idle_gap", 32'(gnt), 32'h0);
      tick();
      chk("m3_next", 32'(gnt), 32'h8);

      // all request: rotation 0,1,2,3,0 with two dead cycles each
      req = 4'b0111;
      tick();
      chk("rr_rel", 32'(gnt), 32'h0);
      req = 4'b1111;
      tick();
      chk("rr_idle", 32'(gnt), 32'h0);
      tick();
      for (int s = 0; s < 5; s++) begin
         chk("rr_gnt", 32'(gnt), 32'(4'b0001 << seq[s]));
         tick();
         chk("rr_hold", 32'(gnt), 32'(4'b0001 << seq[s]));
         tick();
         chk("rr_hold", 32'(gnt), 32'(4'b0001 << seq[s]));
         req = 4'b1111 & ~(4'b0001 << seq[s]);
         tick();
         chk("rr_gap1", 32'(gnt), 32'h0);
         req = 4'b1111;
         tick();
         chk("rr_gap2", 32'(gnt), 32'h0);
         tick();
      end
      chk("rr_wrap", 32'(gnt), 32'h2);
      req = 4'b0000;
      tick();
      tick();
      chk("rr_done", 32'(gnt), 32'h0);

      // owner drops request while select stays high
      req = 4'b0001;
      tick();
      chk("sel_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      sel = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sel_hold", 32'(gnt), 32'h1);
         chk("sel_txa", 32'(txa), 32'h0);
      end
      sel = 1'b0;
      tick();
      chk("sel_rel", 32'(gnt), 32'h0);
      tick();

      // watchdog timeout with no acknowledge
      sel = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("wd_quiet", 32'(txa), 32'h0);
      end
      tick();
      chk("wd_pulse", 32'(txa), 32'h1);
      chk("wd_err", 32'(err), 32'h1);
      tick();
      chk("wd_once", 32'(txa), 32'h0);
      chk("wd_sticky", 32'(err), 32'h1);
      sel  = 1'b0;
      eclr = 1'b1;
      tick();
      chk("wd_clear", 32'(err), 32'h0);
      eclr = 1'b0;

      // real ack on the 8th cycle beats the timeout
      sel = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("ack_quiet", 32'(txa), 32'h0);
      end
      ack = 1'b1;
      tick();
      chk("ack_txa", 32'(txa), 32'h0);
      chk("ack_err", 32'(err), 32'h0);
      sel = 1'b0;
      ack = 1'b0;
      tick();

      // asynchronous reset mid-grant
      req = 4'b1000;
      tick();
      chk("ar_gnt", 32'(gnt), 32'h8);
      rst_n = 1'b0;
      #1;
      chk("ar_drop", 32'(gnt), 32'h0);
      chk("ar_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      req   = 4'b1001;
      tick();
      chk("ar_m0", 32'(gnt), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hba_arbiter.md
Name: hba_arbiter

Overview:
- Bus-grant stage between the HBA bus masters (serial_fpga, future CPU/DMA masters) and the shared HBA slave bus.
- Takes per-master request lines and issues exactly one registered one-hot grant, scheduled round-robin, so the top level no longer ties the bus permanently to serial_fpga.
- Monitors the slave handshake. If a selected transfer receives no hba_xferack within a bounded time, it generates a substitute acknowledge so the master cannot hang.
- Masters drive abus, dbus, rnw and select to zero when not granted; the top level ORs them. This block muxes no data.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 255, hba_clk cycles hba_select may stay high without hba_xferack before a timeout is declared (1..2^CNT_WIDTH-1).
- CNT_WIDTH, 8, width of the transfer watchdog counter.

Ports:
- hba_clk  input  1  bus clock; all state changes on the rising edge.
- hba_reset  input  1  asynchronous, active-low reset.
- master_request  input  NUM_MASTERS  bit i high = master i requests the bus; held until master i is done.
- hba_mgrant  output  NUM_MASTERS  registered one-hot grant; all zero when no master owns the bus.
- hba_select  input  1  OR of master_select lines; a transfer is in progress.
- hba_xferack  input  1  OR of slave xferack lines.
- timeout_xferack  output  1  one-cycle substitute acknowledge, ORed into the master-side xferack by the top level.
- timeout_err  output  1  sticky flag, set on any timeout.
- err_clear  input  1  synchronous clear of timeout_err.
- bus_busy  output  1  high while any grant is active (state GRANT).

Behaviour:
- Reset (hba_reset low, asynchronous):
  - hba_mgrant=0, timeout_xferack=0, timeout_err=0, bus_busy=0.
  - State=IDLE, last_grant pointer=NUM_MASTERS-1, so master 0 has first priority after reset.
  - Watchdog counter=0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any master_request bit is high, pick the first set bit searching from (last_grant+1) mod NUM_MASTERS upward with wrap-around.
  - Register hba_mgrant to that one-hot value and last_grant to its index, then go to GRANT.
  - Latency: request sampled high at edge n gives grant visible after edge n+1 (one cycle). No requests: stay in IDLE with grant 0.
- GRANT:
  - Grant is held while the owner's request is high, or while hba_select is high.
  - Grant drops only when the owner's request is low AND hba_select is low. On that edge: hba_mgrant goes to 0 and the state goes to RELEASE.
  - Requests from other masters are ignored while in GRANT (no preemption).
- RELEASE:
  - One dead cycle with all grants zero, guaranteeing bus turnaround. Unconditionally return to IDLE.
  - Minimum gap between two grants is therefore 2 cycles (RELEASE, then IDLE arbitration).
- Round-robin: after master k is served, k has lowest priority at the next arbitration. With all masters continuously requesting, the grant order is 0,1,2,3,0,...
- Watchdog:
  - Counter clears when hba_select is low or hba_xferack is high. Otherwise it increments each cycle while hba_select is high, saturating at TIMEOUT_CYCLES.
  - When the counter equals TIMEOUT_CYCLES-1 and the cycle has hba_select high and hba_xferack low: assert timeout_xferack for exactly one cycle (registered), set timeout_err, and clear the counter.
  - No further substitute ack is issued until a full new TIMEOUT_CYCLES interval elapses.
  - A real hba_xferack arriving in the same cycle as the timeout condition wins: no timeout_xferack, no error.
  - The watchdog runs independently of state. A select seen in IDLE (protocol violation) is still timed out.
- err_clear: clears timeout_err on the next edge. Set has priority over clear in the same cycle.
- A request on a bit of master_request that is not granted never causes a glitch on hba_mgrant; hba_mgrant is driven only from flops.
- Reset mid-grant: hba_mgrant drops immediately (asynchronous). After release, master 0 has priority.

Test Plan:
- Reset low, then master_request=4'b0100 -> hba_mgrant=4'b0100 exactly one cycle after request sampled; bus_busy=1.
- Master 2 holds the request for 10 cycles, then drops it; masters 0 and 3 request meanwhile -> grant stays 4'b0100 for those 10 cycles; then 1 cycle of 0 (RELEASE), 1 cycle of 0 (IDLE), then 4'b1000 (3 follows 2 before wrapping to 0).
- All four requests held high, each owner drops its request after 3 cycles then re-raises it -> grant sequence 0,1,2,3,0, with exactly 2 zero cycles between grants.
- Owner drops its request while hba_select is high for 5 more cycles -> grant held until hba_select is low, then released.
- hba_select held high, no xferack, TIMEOUT_CYCLES=8 -> timeout_xferack pulses one cycle at the 8th select cycle and timeout_err=1; err_clear then clears it. A repeat run with xferack on cycle 8 -> no pulse, timeout_err stays 0.
- Assert hba_reset low mid-GRANT -> hba_mgrant=0 asynchronously; after release, simultaneous requests 4'b1001 -> master 0 granted first.
